sram_sp_arbiter: RTL
====================

// Module: sram_sp_arbiter
// PURPOSE
//  Shares one single-port SRAM bank (sram_sp_sky130 wrapper) among NUM_REQ requesters.
//  Accepts at most one read or write per cycle, chosen round-robin with bounded bursts.
//  Tags each read and returns its data to the issuing requester after the wrapper's
//  fixed read latency. Sits between the compute/DMA clients and the SRAM wrapper.
// PARAMETERS
//  NUM_REQ     4                    number of requesters (2..8)
//  DATA_BIT    128                  word width; equals wrapper DATA_BIT
//  DEPTH       128                  words; equals wrapper DEPTH
//  ADDR_BIT    $clog2(DEPTH)        address width
//  RD_LATENCY  2                    edges from accepting edge until sram_rdata valid (>=1)
//  BURST_LEN   4                    max consecutive accepts for one requester before rotation (>=1)
// PORTS
//  clk          in   1                  single clock, rising edge
//  rst_n        in   1                  asynchronous, active-low reset
//  req_valid    in   NUM_REQ            request pending, per requester
//  req_ready    out  NUM_REQ            one-hot or zero; request accepted at edge when valid&ready
//  req_wen      in   NUM_REQ            1 = write, 0 = read
//  req_addr     in   NUM_REQ*ADDR_BIT   packed addresses, requester i at [i*ADDR_BIT +: ADDR_BIT]
//  req_wdata    in   NUM_REQ*DATA_BIT   packed write data
//  rsp_valid    out  NUM_REQ            one-hot or zero; read data for requester i this cycle
//  rsp_data     out  DATA_BIT           read data, meaningful only when |rsp_valid
//  busy         out  1                  any read in flight or any req_valid high
//  sram_addr    out  ADDR_BIT           to wrapper addr
//  sram_wen     out  1                  to wrapper wen
//  sram_ren     out  1                  to wrapper ren
//  sram_wdata   out  DATA_BIT           to wrapper wdata
//  sram_rdata   in   DATA_BIT           from wrapper rdata
// BEHAVIOUR
//  - Reset: rr_ptr=0, burst_cnt=0, owner invalid, read pipe cleared. Outputs while rst_n low:
//    req_ready=0, rsp_valid=0, sram_wen=0, sram_ren=0, busy=0. rsp_data, sram_addr and
//    sram_wdata are don't-care.
//  - Grant (combinational): if the owner is valid, req_valid[owner]=1 and burst_cnt<BURST_LEN,
//    the owner wins. Otherwise the first valid requester at or after rr_ptr (wrapping) wins.
//  - Only the winner sees req_ready=1. SRAM pins are muxed from the winner in the same cycle.
//    sram_wen=req_wen[w], sram_ren=~req_wen[w]. With no winner both strobes are 0.
//  - On an accepting edge: if the winner equals the owner, burst_cnt++; otherwise owner=winner
//    and burst_cnt=1. When burst_cnt reaches BURST_LEN, or the owner drops valid,
//    rr_ptr=(owner+1)%NUM_REQ, burst_cnt=0, owner invalid. Wrap from NUM_REQ-1 to 0.
//  - Idle cycles (no winner) leave rr_ptr unchanged and invalidate the owner.
//  - Read return: each accepted read pushes {1,id} into an RD_LATENCY-deep shift pipe.
//    rsp_valid[id]=1 in the cycle after the RD_LATENCY-th edge from acceptance.
//    rsp_data=sram_rdata (pass-through). Back-to-back reads return back-to-back, in order.
//  - Writes produce no response. Write-then-read to the same address on consecutive cycles
//    returns the new data, because the wrapper serialises accesses.
//  - Width rules: addresses are passed through unmodified; no out-of-range check (DEPTH is a
//    power of 2).
//  - Reset mid-operation: in-flight reads are discarded (no rsp_valid after reset release).
//    Requesters must reissue.
//  - Requesters hold valid, wen, addr and wdata stable until accepted; the arbiter does not
//    buffer requests.
// STRUCTURE
//  - Package sram_arb_pkg: ID_BIT=$clog2(NUM_REQ) helper function and the rd_tag_t struct
//    {vld, id}.
//  - Sub-module sram_arb_rr_pick: combinational rotate-priority picker
//    (req vector, ptr -> one-hot grant, index).
//  - Top: owner/burst state, request mux, tag shift pipe, response demux.
// TESTING
//  1. Reset with all req_valid=1 -> req_ready=0, sram_wen=sram_ren=0 until rst_n rises.
//     Then requester 0 is granted first.
//  2. Req0 write 0x5 := 0xA5.., then read 0x5 -> rsp_valid[0] exactly RD_LATENCY cycles after
//     the read accept; rsp_data=0xA5..
//  3. All 4 valid continuously, BURST_LEN=4 -> grants 0,0,0,0,1,1,1,1,2,...,3,0.
//     No cycle has two ready bits high.
//  4. Req1 issues 3 back-to-back reads while req2 reads in between -> four responses,
//     in order, with ids 1,1,2,1 matching issue order.
//  5. Req3 drops valid after 2 accepts -> rotation to req0 on the next cycle.
//     burst_cnt restarts at 1.
//  6. Assert rst_n=0 with 2 reads in flight -> no rsp_valid after release.
//     rr_ptr=0, busy=0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and helpers for the single-port SRAM arbiter
package sram_arb_pkg;

   // Wide enough for the largest supported requester count (8)
   localparam int TAG_ID_BIT = 3;

   typedef struct packed {
      logic                  vld;
      logic [TAG_ID_BIT-1:0] id;
   } rd_tag_t;

   function automatic int id_bit(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sram_arb_rr_pick.sv
// rtl/sram_arb_rr_pick.sv - rotate-priority picker: first set request at or after ptr
module sram_arb_rr_pick
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_BIT  = id_bit(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_BIT-1:0]  ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_BIT-1:0]  idx,
   output logic               vld
);

   always_comb begin : pick
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(ptr) + i) % NUM_REQ;
         if (!vld && req[j]) begin
            vld    = 1'b1;
            idx    = ID_BIT'(j);
            gnt[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_sp_arbiter.sv
// rtl/sram_sp_arbiter.sv - round-robin, burst-bounded arbiter in front of one single-port SRAM
module sram_sp_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_BIT   = 128,
   parameter int DEPTH      = 128,
   parameter int ADDR_BIT   = $clog2(DEPTH),
   parameter int RD_LATENCY = 2,
   parameter int BURST_LEN  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ-1:0]           req_wen,
   input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_BIT-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [DATA_BIT-1:0]          rsp_data,
   output logic                         busy,
   output logic [ADDR_BIT-1:0]          sram_addr,
   output logic                         sram_wen,
   output logic                         sram_ren,
   output logic [DATA_BIT-1:0]          sram_wdata,
   input  logic [DATA_BIT-1:0]          sram_rdata
);

   localparam int ID_BIT  = id_bit(NUM_REQ);
   localparam int CNT_BIT = $clog2(BURST_LEN + 1);

   logic [ID_BIT-1:0]  rr_ptr, rr_ptr_n;
   logic [ID_BIT-1:0]  owner, owner_n;
   logic               owner_vld, owner_vld_n;
   logic [CNT_BIT-1:0] burst_cnt, burst_cnt_n;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [ID_BIT-1:0]  pick_idx;
   logic               pick_vld;
   logic               own_win, win_vld;
   logic [ID_BIT-1:0]  win_idx;

   rd_tag_t [RD_LATENCY-1:0] rd_pipe;
   rd_tag_t                  out_tag;
   logic                     rd_inflight;

   function automatic logic [ID_BIT-1:0] next_id(input logic [ID_BIT-1:0] id);
      return (id == ID_BIT'(NUM_REQ - 1)) ? '0 : id + 1'b1;
   endfunction

   sram_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_BIT  (ID_BIT)
   ) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .vld (pick_vld)
   );

   // The current owner keeps the port until its burst is spent or it goes idle
   always_comb begin
      own_win    = owner_vld & req_valid[owner] & (burst_cnt < CNT_BIT'(BURST_LEN));
      win_vld    = rst_n & (own_win | pick_vld);
      win_idx    = own_win ? owner : pick_idx;
      req_ready  = '0;
      if (win_vld)
         req_ready = own_win ? (NUM_REQ'(1) << owner) : pick_gnt;
      sram_addr  = req_addr[int'(win_idx)*ADDR_BIT +: ADDR_BIT];
      sram_wdata = req_wdata[int'(win_idx)*DATA_BIT +: DATA_BIT];
      sram_wen   = win_vld & req_wen[win_idx];
      sram_ren   = win_vld & ~req_wen[win_idx];
   end

   always_comb begin
      rr_ptr_n    = rr_ptr;
      owner_n     = owner;
      owner_vld_n = owner_vld;
      burst_cnt_n = burst_cnt;
      if (win_vld) begin
         if (owner_vld && !req_valid[owner])
            rr_ptr_n = next_id(owner);
         if (own_win) begin
            burst_cnt_n = burst_cnt + 1'b1;
         end else begin
            owner_n     = win_idx;
            burst_cnt_n = CNT_BIT'(1);
         end
         owner_vld_n = 1'b1;
         if (burst_cnt_n == CNT_BIT'(BURST_LEN)) begin
            rr_ptr_n    = next_id(win_idx);
            owner_vld_n = 1'b0;
            burst_cnt_n = '0;
         end
      end else begin
         owner_vld_n = 1'b0;
         burst_cnt_n = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         owner     <= '0;
         owner_vld <= 1'b0;
         burst_cnt <= '0;
      end else begin
         rr_ptr    <= rr_ptr_n;
         owner     <= owner_n;
         owner_vld <= owner_vld_n;
         burst_cnt <= burst_cnt_n;
      end
   end

   // Tag pipe mirrors the wrapper's read latency so the id lines up with sram_rdata
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe[0] <= '{vld: sram_ren, id: TAG_ID_BIT'(win_idx)};
         for (int i = 1; i < RD_LATENCY; i++)
            rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   always_comb begin
      rd_inflight = 1'b0;
      for (int i = 0; i < RD_LATENCY; i++)
         rd_inflight = rd_inflight | rd_pipe[i].vld;
      out_tag   = rd_pipe[RD_LATENCY-1];
      rsp_valid = out_tag.vld ? (NUM_REQ'(1) << out_tag.id[ID_BIT-1:0]) : '0;
      rsp_data  = sram_rdata;
      busy      = rst_n & (rd_inflight | (|req_valid));
   end

endmodule
